multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Multicycle control FSM for the RV32 subset core.
- Steps each instruction through fetch, decode, execute, optional memory and writeback.
- Drives the instruction and data memory request/acknowledge handshakes.
- Takes the decoder strobes (meml, mems, regw, aluimm) and turns them into per-cycle datapath enables, plus halt/fault status and a retired-instruction count.

Parameters:
- TIMEOUT, 15: maximum wait cycles tolerated on imem_ack or dmem_ack before entering FAULT.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- run  input  1  enables fetching; sampled in IDLE and at each WB exit.
- op  input  7  opcode field of the instruction register.
- meml  input  1  decoder strobe: instruction is a load.
- mems  input  1  decoder strobe: instruction is a store.
- regw  input  1  decoder strobe: instruction writes the register file.
- aluimm  input  1  decoder strobe: ALU B operand is the immediate.
- imem_ack  input  1  instruction memory data valid.
- dmem_ack  input  1  data memory access complete.
- imem_req  output  1  instruction fetch request.
- ir_we  output  1  instruction register load strobe.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write (store).
- alu_src_imm  output  1  ALU B operand mux select.
- rf_we  output  1  register file write enable.
- pc_we  output  1  PC update strobe.
- state  output  3  current state code.
- halted  output  1  core stopped on SYSTEM opcode.
- fault  output  1  handshake timeout occurred.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Reset (rst=1 at a clock edge):
  - state=IDLE, wait counter=0, retired=0, latched strobes=0.
  - All outputs 0.
  - rst overrides every transition, including mid-handshake, HALT and FAULT.
- IDLE: go to FETCH when run=1, otherwise stay.
- FETCH:
  - imem_req=1.
  - ir_we = imem_ack (Mealy output, same cycle).
  - On imem_ack go to DECODE; else increment wait counter.
- DECODE:
  - Latch meml, mems, regw, aluimm, and SYSTEM-ness (op==7'b1110011) into internal registers.
  - Go to EXEC.
  - The latched values drive all later states; input changes after DECODE have no effect.
- EXEC:
  - alu_src_imm = latched aluimm.
  - Go to MEM if latched meml or mems, else go to WB.
- MEM:
  - dmem_req=1.
  - dmem_we = latched mems (never 1 for a load).
  - On dmem_ack go to WB; else increment wait counter.
  - If both meml and mems are latched (illegal), treat as store.
- WB (exactly one cycle):
  - rf_we = latched regw.
  - pc_we = 1, unless the latched instruction is SYSTEM.
  - retired increments by 1, wrapping from 2^CNT_W-1 to 0. SYSTEM counts as retired.
  - Next state: HALT if SYSTEM; else FETCH if run=1; else IDLE.
- HALT: halted=1 and all enables 0. Exit only on rst.
- FAULT: fault=1 and all enables 0. Exit only on rst. retired is frozen.
- Outputs: all except ir_we are Moore, decoded from state and latched strobes only.
- Wait counter:
  - Width is clog2(TIMEOUT+1).
  - Cleared on every entry to FETCH or MEM.
  - If it equals TIMEOUT and ack is low, the next state is FAULT.
  - An ack arriving in the same cycle the counter equals TIMEOUT is accepted normally (ack wins).
  - An instruction therefore gets TIMEOUT+1 request cycles before faulting.
- Spurious acks: imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Latency with zero-wait acks (ack in the first request cycle):
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.

Test Plan:
- rst, then run=1, op=0110011, regw=1, acks tied high.
  - Required: state sequence 0,1,2,3,5,1.
  - Required: rf_we and pc_we high only in the WB cycle; retired=1 after the first WB.
- Load (meml=1, regw=1, aluimm=1) with dmem_ack raised after 3 MEM cycles.
  - Required: dmem_req high for 4 cycles, dmem_we=0, rf_we=1 in WB.
  - Required: instruction takes 8 cycles in total.
- Store (mems=1, regw=0).
  - Required: dmem_we=1 throughout MEM, rf_we=0 and pc_we=1 in WB.
- imem_ack held low with TIMEOUT=15.
  - Required: 16 FETCH cycles, then state=7 and fault=1.
  - Required: fault persists with run=1 until rst, then state=0 and fault=0.
- Boundary ack, imem_ack raised exactly on the 16th FETCH cycle.
  - Required: DECODE next, no fault.
- op=1110011.
  - Required: WB has pc_we=0; then state=6 with halted=1, and the count has increased by one.
- run dropped during EXEC.
  - Required: WB goes to IDLE; re-asserting run resumes at FETCH.
- Counter wrap, CNT_W=4, 16 instructions retired.
  - Required: retired wraps to 0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the RV32 subset core.
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// turning the latched decoder strobes into per-cycle datapath enables.
//
// Handshakes: imem_req/dmem_req are level requests held high for every
// cycle spent in FETCH/MEM. The matching ack completes the transfer in the
// cycle it is seen high while the request is up. An ack seen while the
// request is low is ignored. Each request gets TIMEOUT+1 cycles; if the
// last of them passes without an ack, the sequencer parks in FAULT.
module multicycle_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       op,
    input  logic             meml,
    input  logic             mems,
    input  logic             regw,
    input  logic             aluimm,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             alu_src_imm,
    output logic             rf_we,
    output logic             pc_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [2:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              ld_q, ld_d;
    logic              st_q, st_d;
    logic              regw_q, regw_d;
    logic              aluimm_q, aluimm_d;
    logic              sys_q, sys_d;

    // Next-state, wait counter, retire counter and strobe latching.
    // The wait counter only counts while a request goes unanswered; any
    // other cycle leaves it at zero, so it starts clean on each FETCH/MEM.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        retired_d = retired_q;
        ld_d      = ld_q;
        st_d      = st_q;
        regw_d    = regw_q;
        aluimm_d  = aluimm_q;
        sys_d     = sys_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack)              state_d = S_DECODE;
                else if (wait_q == WAIT_MAX) state_d = S_FAULT;
                else                       wait_d  = wait_q + WAIT_W'(1);
            end
            S_DECODE: begin
                ld_d     = meml;
                st_d     = mems;
                regw_d   = regw;
                aluimm_d = aluimm;
                sys_d    = (op == OP_SYSTEM);
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                state_d = (ld_q || st_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack)              state_d = S_WB;
                else if (wait_q == WAIT_MAX) state_d = S_FAULT;
                else                       wait_d  = wait_q + WAIT_W'(1);
            end
            S_WB: begin
                retired_d = retired_q + CNT_W'(1);
                if (sys_q)    state_d = S_HALT;
                else if (run) state_d = S_FETCH;
                else          state_d = S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            regw_q    <= 1'b0;
            aluimm_q  <= 1'b0;
            sys_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            ld_q      <= ld_d;
            st_q      <= st_d;
            regw_q    <= regw_d;
            aluimm_q  <= aluimm_d;
            sys_q     <= sys_d;
        end
    end

    // Output decode: Moore from state and latched strobes, except ir_we
    // which follows imem_ack in the same FETCH cycle. A load+store combo
    // behaves as a store because dmem_we only looks at the store strobe.
    always_comb begin
        imem_req    = (state_q == S_FETCH);
        ir_we       = (state_q == S_FETCH) && imem_ack;
        dmem_req    = (state_q == S_MEM);
        dmem_we     = (state_q == S_MEM) && st_q;
        alu_src_imm = (state_q == S_EXEC) && aluimm_q;
        rf_we       = (state_q == S_WB) && regw_q;
        pc_we       = (state_q == S_WB) && !sys_q;
        halted      = (state_q == S_HALT);
        fault       = (state_q == S_FAULT);
        state       = state_q;
        retired     = retired_q;
    end

endmodule
